lcd_hex_formatter: RTL and testbench
====================================

# lcd_hex_formatter

Upstream formatting stage for the character-LCD write path. It accepts a processor word over a valid/ready handshake and converts it to a byte stream for the LCD writer: one HD44780 set-DDRAM-address command, then the word as uppercase ASCII hex digits, MSB first. It also suppresses repeat writes of an unchanged value to the same line, which avoids display flicker and wasted LCD bus time.

## Interface
- DATA_W, 18: width of input word.
- NDIG, (DATA_W+3)/4 = 5: hex digits emitted per word; derived, not overridable.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_data/in_line valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  word to display.
- in_line  in  1  target LCD row, 0 or 1.
- out_valid  out  1  out_byte/out_rs valid.
- out_ready  in  1  LCD writer consumes the byte.
- out_byte  out  8  command or character byte.
- out_rs  out  1  0 = command, 1 = character data.
- busy  out  1  a sequence is in progress (state != IDLE).

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - CMD: emit the address byte.
  - DIGIT: emit digits; digit counter dig runs 0..NDIG-1.
- Accept happens on a clock edge where in_valid & in_ready are both high.
- Duplicate check on accept: if last_vld[in_line] and in_data == last_word[in_line], drop the word. State stays IDLE, no output, in_ready stays 1.
- Otherwise:
  - Latch word and line.
  - Set last_word[line] = in_data and last_vld[line] = 1.
  - Go to CMD.
- CMD byte: out_byte = 8'h80 | (line ? 8'h40 : 8'h00), out_rs = 0.
  - On transfer (out_valid & out_ready), go to DIGIT with dig = 0.
- DIGIT:
  - The word is zero-extended on the left to 4*NDIG bits.
  - Digit dig is nibble (NDIG-1-dig). For DATA_W=18, digit 0 = {2'b00, w[17:16]}.
  - ASCII mapping: n<10 gives 8'h30+n; otherwise 8'h37+n ('A'..'F'). out_rs = 1.
  - On transfer: if dig == NDIG-1, go to IDLE; else dig increments.
- Output holding: while out_valid & !out_ready, out_byte and out_rs are held stable. out_valid never drops without a transfer.
- Input while busy: in_ready=0, in_data is ignored, and no buffering is done.
- Reset values:
  - state=IDLE, dig=0, last_vld=2'b00.
  - out_valid=0, out_byte=8'h00, out_rs=0, busy=0.
  - in_ready=0 while rst is high, 1 on the first cycle after.
- Reset mid-sequence: the sequence is abandoned immediately and no further bytes are emitted. last_vld is cleared, so the next word for either line is always displayed.

## Timing
- Latency: out_valid rises on the cycle after the accept edge, presenting the CMD byte.
- With out_ready held at 1: CMD plus NDIG digits take 6 consecutive transfer cycles.
- in_ready returns to 1 on the cycle after the final digit transfer. Peak throughput is 1 word per 7 cycles.
- A dropped duplicate takes 1 cycle; a back-to-back accept is possible on the next edge.
- All outputs are registered except in_ready and busy, which are decoded from state and rst.

## Structure
- Package lcd_pkg holds:
  - LCD_CMD_SET_DDRAM = 8'h80 and LCD_LINE1_OFFSET = 8'h40.
  - ASCII_ZERO = 8'h30 and ASCII_HEX_ALPHA_BASE = 8'h37.
  - The state enum {IDLE, CMD, DIGIT}.
- One sub-module, lcd_hex_ascii: combinational 4-bit nibble to 8-bit ASCII.

## Test plan
- rst, then word 18'h2ABCD on line 0 with out_ready=1 -> bytes 80(rs0), 32, 41, 42, 43, 44 (rs1) on 6 consecutive cycles; in_ready high on the next cycle.
- Line 1, word 18'h3FFFF, then 18'h00000 on line 1 -> C0, 33, 46, 46, 46, 46, then C0, 30, 30, 30, 30, 30.
- Random out_ready stalls on word 18'h01234 -> byte stable during every stall; exact sequence 80, 30, 31, 32, 33, 34; no lost or duplicated bytes.
- Duplicate suppression:
  - 18'h12345 to line 0 twice -> second accepted in 1 cycle with no output.
  - Same value to line 1 -> displayed (C0 ...).
  - 18'h12346 to line 0 -> displayed.
- in_valid pulsed with a different word during a sequence -> in_ready=0, word ignored, current sequence unchanged.
- rst asserted after the 3rd digit transfer -> out_valid=0 next cycle; resending the same word displays it in full.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the character-LCD formatting path.
package lcd_pkg;

  // HD44780 set-DDRAM-address command and the row-1 address offset.
  localparam logic [7:0] LCD_CMD_SET_DDRAM    = 8'h80;
  localparam logic [7:0] LCD_LINE1_OFFSET     = 8'h40;

  // ASCII bases: '0' for 0..9, and 'A'-10 for 10..15.
  localparam logic [7:0] ASCII_ZERO           = 8'h30;
  localparam logic [7:0] ASCII_HEX_ALPHA_BASE = 8'h37;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DIGIT
  } state_t;

endpackage

// File: rtl/lcd_hex_ascii.sv
// Combinational 4-bit nibble to uppercase ASCII hex character.
module lcd_hex_ascii
  import lcd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  // Pick the digit or letter base, then add the nibble value.
  always_comb begin
    if (nibble_i < 4'd10) begin
      ascii_o = ASCII_ZERO + {4'b0000, nibble_i};
    end else begin
      ascii_o = ASCII_HEX_ALPHA_BASE + {4'b0000, nibble_i};
    end
  end

endmodule

// File: rtl/lcd_hex_formatter.sv
// Converts a processor word into an LCD byte stream: one set-DDRAM-address
// command followed by the word as uppercase hex digits, MSB first. Repeat
// writes of an unchanged value to the same row are dropped.
module lcd_hex_formatter
  import lcd_pkg::*;
#(
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_line,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_rs,
  output logic              busy
);

  localparam int NDIG  = (DATA_W + 3) / 4;
  localparam int HEX_W = 4 * NDIG;
  localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NDIG - 1);

  state_t            state_q;
  logic [DIG_W-1:0]  dig_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] last_word_q [2];
  logic [1:0]        last_vld_q;
  logic              out_valid_q;
  logic [7:0]        out_byte_q;
  logic              out_rs_q;

  logic              accept;
  logic              is_dup;
  logic [7:0]        cmd_byte;
  logic [DIG_W-1:0]  fetch_dig;
  logic [DIG_W-1:0]  nib_sel;
  logic [HEX_W-1:0]  hex_word;
  logic [3:0]        fetch_nibble;
  logic [7:0]        fetch_ascii;

  // Handshake decode, duplicate test and the next digit to present.
  // fetch_dig is the digit that becomes visible after the current transfer:
  // digit 0 when leaving CMD, otherwise the one after dig_q.
  always_comb begin
    accept       = in_valid & in_ready;
    is_dup       = last_vld_q[in_line] && (in_data == last_word_q[in_line]);
    cmd_byte     = LCD_CMD_SET_DDRAM | (in_line ? LCD_LINE1_OFFSET : 8'h00);
    fetch_dig    = (state_q == CMD) ? '0 : dig_q + DIG_W'(1);
    nib_sel      = LAST_DIG - fetch_dig;
    hex_word     = HEX_W'(word_q);
    fetch_nibble = 4'(hex_word >> {nib_sel, 2'b00});
  end

  lcd_hex_ascii u_hex_ascii (
    .nibble_i (fetch_nibble),
    .ascii_o  (fetch_ascii)
  );

  // Sequencer: accept/drop words, then walk CMD and DIGIT with registered
  // outputs that only advance on a transfer, so stalls hold the byte.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dig_q       <= '0;
      word_q      <= '0;
      last_vld_q  <= 2'b00;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
      out_rs_q    <= 1'b0;
      // NOTE: last_word_q is storage only; last_vld_q gates it, so it needs no reset.
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept && !is_dup) begin
            word_q               <= in_data;
            last_word_q[in_line] <= in_data;
            last_vld_q[in_line]  <= 1'b1;
            out_valid_q          <= 1'b1;
            out_byte_q           <= cmd_byte;
            out_rs_q             <= 1'b0;
            state_q              <= CMD;
          end
        end
        CMD: begin
          if (out_ready) begin
            dig_q      <= '0;
            out_byte_q <= fetch_ascii;
            out_rs_q   <= 1'b1;
            state_q    <= DIGIT;
          end
        end
        DIGIT: begin
          if (out_ready) begin
            if (dig_q == LAST_DIG) begin
              dig_q       <= '0;
              out_valid_q <= 1'b0;
              state_q     <= IDLE;
            end else begin
              dig_q      <= fetch_dig;
              out_byte_q <= fetch_ascii;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = !rst && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_rs    = out_rs_q;

endmodule

// File: tb/tb_lcd_hex_formatter.sv
// Self-checking bench for lcd_hex_formatter: table vectors, hand-written
// corner sequences and randomized words checked against a byte-stream model.
module tb_lcd_hex_formatter;

  localparam int DATA_W = 18;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_line;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic              out_rs;
  logic              busy;

  lcd_hex_formatter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_line   (in_line),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_rs    (out_rs),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observed and expected streams of {rs, byte}.
  typedef logic [8:0] ob_t;
  ob_t got[$];
  ob_t exp_q[$];

  // Transfer monitor and stall-stability watcher, sampled on the falling edge.
  int   stall_err = 0;
  logic prev_stall = 1'b0;
  ob_t  prev_ob;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(out_valid && ({out_rs, out_byte} == prev_ob))) stall_err++;
      if (out_valid && out_ready) got.push_back({out_rs, out_byte});
      prev_stall = out_valid && !out_ready;
      prev_ob    = {out_rs, out_byte};
    end
  end

  // Reference model: last displayed word per row, and the byte stream rule.
  logic [DATA_W-1:0] m_last [2];
  logic              m_vld  [2];
  string             hexchars = "0123456789ABCDEF";

  task automatic build_expected(input logic [DATA_W-1:0] w, input logic ln);
    int n;
    exp_q.delete();
    exp_q.push_back({1'b0, (ln ? 8'hC0 : 8'h80)});
    for (int i = 0; i < 5; i++) begin
      n = (int'(w) >> (4 * (4 - i))) & 15;
      exp_q.push_back({1'b1, hexchars[n]});
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
  endtask

  // Drive one word from posedge+1, drain the sequence, compare against exp_q.
  task automatic run_word(input logic [DATA_W-1:0] w, input logic ln,
                          input bit rnd, input bit shown, input string tag);
    int cycles;
    got.delete();
    if (!shown) exp_q.delete();
    in_valid = 1'b1;
    in_data  = w;
    in_line  = ln;
    check({tag, "_in_ready_idle"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (shown) begin
      check({tag, "_latency_valid"}, out_valid, 1);
      check({tag, "_first_byte"}, {out_rs, out_byte}, exp_q[0]);
    end else begin
      check({tag, "_dup_no_output"}, {busy, out_valid}, 0);
      check({tag, "_dup_in_ready"}, in_ready, 1);
    end
    cycles = 0;
    while (busy && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check({tag, "_timeout"}, busy, 0);
    if (shown && !rnd) check({tag, "_cycles"}, cycles, 6);
    check({tag, "_in_ready_after"}, in_ready, 1);
    compare_stream(tag);
    if (shown) begin
      m_last[ln] = w;
      m_vld[ln]  = 1'b1;
    end
    out_ready = 1'b1;
  endtask

  typedef struct {
    logic [DATA_W-1:0] w;
    logic              ln;
    bit                rnd;
    bit                shown;
    logic [7:0]        cmd;
    logic [39:0]       digs;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] w;
    logic              ln;
    bit                shown;

    tbl[0] = '{18'h2ABCD, 1'b0, 1'b0, 1'b1, 8'h80, "2ABCD"};
    tbl[1] = '{18'h3FFFF, 1'b1, 1'b0, 1'b1, 8'hC0, "3FFFF"};
    tbl[2] = '{18'h00000, 1'b1, 1'b0, 1'b1, 8'hC0, "00000"};
    tbl[3] = '{18'h01234, 1'b0, 1'b1, 1'b1, 8'h80, "01234"};
    tbl[4] = '{18'h12345, 1'b0, 1'b0, 1'b1, 8'h80, "12345"};
    tbl[5] = '{18'h12345, 1'b0, 1'b0, 1'b0, 8'h00, "-----"};
    tbl[6] = '{18'h12345, 1'b1, 1'b0, 1'b1, 8'hC0, "12345"};
    tbl[7] = '{18'h12346, 1'b0, 1'b0, 1'b1, 8'h80, "12346"};

    m_vld[0] = 1'b0;
    m_vld[1] = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_line   = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 8'h00);
    check("rst_out_rs", out_rs, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    // Table vectors with hand-derived byte streams.
    for (int i = 0; i < 8; i++) begin
      exp_q.delete();
      if (tbl[i].shown) begin
        exp_q.push_back({1'b0, tbl[i].cmd});
        for (int k = 0; k < 5; k++) exp_q.push_back({1'b1, tbl[i].digs[39-8*k -: 8]});
      end
      run_word(tbl[i].w, tbl[i].ln, tbl[i].rnd, tbl[i].shown, $sformatf("vec%0d", i));
    end

    // Input while busy: a different word pulsed mid-sequence is ignored.
    got.delete();
    build_expected(18'h0AAAA, 1'b0);
    in_valid = 1'b1; in_data = 18'h0AAAA; in_line = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 18'h0BBBB; in_line = 1'b1;
    check("busy_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_still_busy", busy, 1);
    for (int c = 0; c < 20 && busy; c++) begin
      @(posedge clk); #1;
    end
    check("busy_done", busy, 0);
    compare_stream("busy_seq");
    m_last[0] = 18'h0AAAA;
    // The ignored word was never recorded, so it must display now.
    build_expected(18'h0BBBB, 1'b1);
    run_word(18'h0BBBB, 1'b1, 1'b0, 1'b1, "after_ignored");

    // Reset after the third digit transfer abandons the sequence.
    got.delete();
    in_valid = 1'b1; in_data = 18'h2ABCD; in_line = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    m_vld[0] = 1'b0;
    m_vld[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_bytes_before", got.size(), 4);
    check("midrst_idle_out_valid", out_valid, 0);
    build_expected(18'h2ABCD, 1'b0);
    run_word(18'h2ABCD, 1'b0, 1'b0, 1'b1, "resend");

    // Randomized words, rows and stalls against the model.
    for (int i = 0; i < 30; i++) begin
      ln = 1'($urandom_range(0, 1));
      if (m_vld[ln] && $urandom_range(0, 3) == 0) w = m_last[ln];
      else w = DATA_W'($urandom);
      shown = !(m_vld[ln] && (w == m_last[ln]));
      if (shown) build_expected(w, ln);
      run_word(w, ln, 1'($urandom_range(0, 1)), shown, $sformatf("rnd%0d", i));
    end

    check("stall_stability", stall_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
